// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, ALU op indices, memory size codes and bus layouts
package cpu_defs;

    localparam int DS_ES_W  = 158;
    localparam int ES_MS_W  = 77;
    localparam int ALU_OP_W = 19;

    localparam int ALU_ADD    = 0;
    localparam int ALU_DIV_W  = 15;
    localparam int ALU_MOD_W  = 16;
    localparam int ALU_DIV_WU = 17;
    localparam int ALU_MOD_WU = 18;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam int DS_PC_LSB   = 0;
    localparam int DS_OP_LSB   = 32;
    localparam int DS_SRC1_LSB = 51;
    localparam int DS_SRC2_LSB = 83;
    localparam int DS_DEST_LSB = 115;
    localparam int DS_RKD_LSB  = 125;

    localparam int ES_RESULT_LSB = 32;
    localparam int ES_DEST_LSB   = 64;
    localparam int ES_ALE        = 76;

    typedef struct packed {
        logic                mem_uns;
        logic [31:0]         rkd_value;
        logic [1:0]          mem_size;
        logic                mem_rd;
        logic                mem_we;
        logic                gr_we;
        logic [4:0]          dest;
        logic [31:0]         alu_src2;
        logic [31:0]         alu_src1;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         pc;
    } ds_es_t;

    typedef struct packed {
        logic        ale;
        logic [1:0]  addr_lo;
        logic        mem_uns;
        logic [1:0]  mem_size;
        logic        mem_rd;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_ms_t;

    function automatic logic op_is_div(input logic [ALU_OP_W-1:0] op);
        return op[ALU_DIV_W] | op[ALU_MOD_W] | op[ALU_DIV_WU] | op[ALU_MOD_WU];
    endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - byte-lane write mask, replicated store data and misalignment flag
module store_align
    import cpu_defs::*;
(
    input  logic [1:0]  mem_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rkd,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata,
    output logic        ale
);

    always_comb begin
        we_mask = 4'b0000;
        wdata   = rkd;
        ale     = 1'b0;
        case (mem_size)
            MEM_SIZE_B: begin
                we_mask = 4'b0001 << addr_lo;
                wdata   = {4{rkd[7:0]}};
            end
            MEM_SIZE_H: begin
                we_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{rkd[15:0]}};
                ale     = addr_lo[0];
            end
            MEM_SIZE_W: begin
                we_mask = 4'b1111;
                wdata   = rkd;
                ale     = (addr_lo != 2'b00);
            end
            default: begin
                we_mask = 4'b0000;
                wdata   = rkd;
                ale     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - LA32R execute stage: ALU drive, divide hold/drain, data-SRAM request, forwarding
module exe_stage
    import cpu_defs::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ds_to_es_valid,
    input  logic [DS_ES_W-1:0]  ds_to_es_bus,
    output logic                es_allowin,
    input  logic                ms_allowin,
    output logic                es_to_ms_valid,
    output logic [ES_MS_W-1:0]  es_to_ms_bus,
    input  logic                flush,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    output logic                exe_valid,
    input  logic [31:0]         alu_result,
    input  logic                alu_done,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    output logic                es_fwd_valid,
    output logic                es_fwd_blocking,
    output logic [4:0]          es_fwd_dest,
    output logic [31:0]         es_fwd_data
);

    ds_es_t      bundle;
    logic        es_valid;
    logic        div_hold;
    logic        div_drain;
    logic [31:0] div_res;

    logic        is_div;
    logic        es_ready_go;
    logic        es_leave;
    logic [31:0] es_result;
    logic [3:0]  we_mask;
    logic        ale;
    es_ms_t      ms_bundle;

    assign is_div      = op_is_div(bundle.alu_op);
    assign es_ready_go = ~is_div | alu_done | div_hold;
    assign es_result   = div_hold ? div_res : alu_result;
    assign es_allowin  = ~div_drain & (~es_valid | (es_ready_go & ms_allowin));
    assign es_leave    = es_valid & es_ready_go & ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid  <= 1'b0;
            div_hold  <= 1'b0;
            div_drain <= 1'b0;
            div_res   <= 32'd0;
            bundle    <= '0;
        end else begin
            if (flush)
                es_valid <= 1'b0;
            else if (es_allowin)
                es_valid <= ds_to_es_valid;

            if (es_allowin && ds_to_es_valid)
                bundle <= ds_es_t'(ds_to_es_bus);

            // Capture a finished divide so ms back-pressure cannot lose the one-cycle result.
            if (flush || es_leave)
                div_hold <= 1'b0;
            else if (es_valid && is_div && alu_done && !div_hold) begin
                div_hold <= 1'b1;
                div_res  <= alu_result;
            end

            // A flushed in-flight divide keeps its operands presented until the divider finishes.
            if (flush && es_valid && is_div && !alu_done && !div_hold)
                div_drain <= 1'b1;
            else if (div_drain && alu_done)
                div_drain <= 1'b0;
        end
    end

    assign alu_op         = bundle.alu_op;
    assign alu_src1       = bundle.alu_src1;
    assign alu_src2       = bundle.alu_src2;
    assign exe_valid      = es_valid & ~div_hold & ~flush & ~div_drain;
    assign es_to_ms_valid = es_valid & es_ready_go & ~flush;

    store_align u_store_align (
        .mem_size (bundle.mem_size),
        .addr_lo  (alu_result[1:0]),
        .rkd      (bundle.rkd_value),
        .we_mask  (we_mask),
        .wdata    (data_sram_wdata),
        .ale      (ale)
    );

    assign data_sram_en   = es_valid & (bundle.mem_rd | bundle.mem_we) & ~ale & ms_allowin & ~flush;
    assign data_sram_we   = bundle.mem_we ? we_mask : 4'b0000;
    assign data_sram_addr = alu_result;

    always_comb begin
        ms_bundle          = '0;
        ms_bundle.ale      = ale;
        ms_bundle.addr_lo  = alu_result[1:0];
        ms_bundle.mem_uns  = bundle.mem_uns;
        ms_bundle.mem_size = bundle.mem_size;
        ms_bundle.mem_rd   = bundle.mem_rd;
        ms_bundle.gr_we    = bundle.gr_we;
        ms_bundle.dest     = bundle.dest;
        ms_bundle.result   = es_result;
        ms_bundle.pc       = bundle.pc;
    end
    assign es_to_ms_bus = ms_bundle;

    assign es_fwd_valid    = es_valid & bundle.gr_we & (bundle.dest != 5'd0);
    assign es_fwd_blocking = es_fwd_valid & (bundle.mem_rd | ~es_ready_go);
    assign es_fwd_dest     = bundle.dest;
    assign es_fwd_data     = es_result;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute pipeline stage of the LA32R five-stage core. Sits between the decode stage (ds) and the memory stage (ms).
- Latches the ds→es bundle and drives the ALU operands and op vector.
- Holds the instruction until multi-cycle divide results are available.
- Issues the data-SRAM request for loads/stores and publishes a forwarding/blocking bus back to decode.
- Passes the es→ms bundle downstream under valid/allowin handshaking.

Parameters:
- DS_ES_W, 158, width of ds_to_es_bus.
- ES_MS_W, 77, width of es_to_ms_bus.
- ALU_OP_W, 19, width of the ALU one-hot op vector.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ds_to_es_valid  in  1  decode has a valid instruction
- ds_to_es_bus  in  DS_ES_W  {mem_uns, rkd_value[31:0], mem_size[1:0], mem_rd, mem_we, gr_we, dest[4:0], alu_src2[31:0], alu_src1[31:0], alu_op[18:0], pc[31:0]}, MSB first
- es_allowin  out  1  stage can accept a new instruction this cycle
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  bundle valid to ms
- es_to_ms_bus  out  ES_MS_W  {ale, addr_lo[1:0], mem_uns, mem_size[1:0], mem_rd, gr_we, dest[4:0], result[31:0], pc[31:0]}
- flush  in  1  writeback exception/ertn flush
- alu_op  out  ALU_OP_W  latched op vector to the ALU
- alu_src1, alu_src2  out  32  latched operands
- exe_valid  out  1  ALU qualifier (starts divides)
- alu_result  in  32  ALU result
- alu_done  in  1  ALU done flag (low while a divide is pending; high for one cycle when a divide result is valid)
- data_sram_en  out  1  SRAM request strobe
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  replicated store data
- es_fwd_valid  out  1  es will write GR dest
- es_fwd_blocking  out  1  decode must stall on a dependence
- es_fwd_dest  out  5  destination register
- es_fwd_data  out  32  forwarded result

Behaviour:
- Reset: es_valid=0, div_hold=0, div_drain=0, bundle regs=0. Every output is 0 except es_allowin=1.
- is_div = alu_op[15] | alu_op[16] | alu_op[17] | alu_op[18].
- Divide capture:
  - When es_valid & is_div & alu_done & ~div_hold: latch div_res ← alu_result, set div_hold=1.
  - Clear div_hold when the instruction leaves the stage or on flush.
- es_result = div_hold ? div_res : alu_result.
- es_ready_go = ~is_div | alu_done | div_hold.
- es_allowin = ~div_drain & (~es_valid | (es_ready_go & ms_allowin)).
- es_to_ms_valid = es_valid & es_ready_go & ~flush.
- es_valid update:
  - flush → 0 (takes priority).
  - Else if es_allowin → ds_to_es_valid.
  - Bundle regs load on es_allowin & ds_to_es_valid.
- exe_valid = es_valid & ~div_hold & ~flush & ~div_drain. This prevents a finished divide being relaunched while the stage waits on ms.
- Flush mid-divide:
  - If flush while es_valid & is_div & ~alu_done & ~div_hold: set div_drain=1.
  - Clear div_drain on the first cycle alu_done is high with the divide op still presented. Keep alu_op/src regs frozen until then.
  - Drained result is discarded.
- Memory request:
  - addr = alu_result (adder output).
  - ale = (mem_size==2'b01 & addr[0]) | (mem_size==2'b10 & addr[1:0]!=0). mem_size: 0=byte, 1=half, 2=word.
  - data_sram_en = es_valid & (mem_rd|mem_we) & ~ale & ms_allowin & ~flush. The request is issued exactly once, in the cycle the instruction moves to ms.
  - data_sram_we = mem_we ? byte mask : 0. Masks: byte→1<<addr[1:0]; half→addr[1] ? 4'b1100 : 4'b0011; word→4'b1111.
  - data_sram_wdata: byte→{4{rkd[7:0]}}; half→{2{rkd[15:0]}}; word→rkd.
- Forwarding:
  - es_fwd_valid = es_valid & gr_we & dest!=0.
  - es_fwd_blocking = es_fwd_valid & (mem_rd | ~es_ready_go).
  - es_fwd_dest = dest; es_fwd_data = es_result.
- Back-pressure: with ms_allowin=0 and es_ready_go=1, all registers hold and div_res is retained. alu_result may change but is not used once div_hold=1.

Decomposition:
- Shared package cpu_defs: DS_ES_W, ES_MS_W, ALU_OP_W, alu_op bit indices (ALU_DIV_W=15 … ALU_MOD_WU=18), MEM_SIZE_B/H/W encodings, bus field offsets.
- One sub-module, store_align: combinational mem_size, addr_lo, rkd → we mask, wdata, ale.
- The ALU is instantiated by the core top, not inside this stage.

Test Plan:
- add.w with src1=5, src2=7, ms_allowin=1 → es_to_ms_valid next cycle, result=12. es_fwd_blocking=0, es_allowin stays 1.
- div.w 100/-7: alu_done low for N cycles → es_allowin=0 and es_fwd_blocking=1 throughout. On the done pulse, result=0xFFFFFFF2 (−14) and es_to_ms_valid=1.
- div.wu with ms_allowin=0 held 5 cycles after alu_done pulse → result stays 0x… captured value. exe_valid=0 after capture; one handoff when ms_allowin rises.
- st.b rkd=0x000000AB, addr=0x1003 → data_sram_en=1 for exactly one cycle, we=4'b1000, wdata=0xABABABAB. st.h at 0x1001 → ale=1, en=0.
- flush asserted 2 cycles into mod.w → es_valid=0, es_allowin=0 until alu_done. Next instruction (add 1+1) then yields 2, and no stale divide result appears.
- ld.w with dest=r4 → es_fwd_blocking=1, data_sram_en=1, we=0. reset asserted mid-stream → all outputs 0 next cycle and es_allowin=1.
